// File: rtl/mod_arith_rsd2bin.sv
// Word-serial conversion of an RSD operand pair (up, un) into the canonical residue (up - un) mod M.
// Define RSD_CONV_ZERO_FLG_EN to add the out_zero flag, which reports dout == 0 alongside out_valid.
module mod_arith_rsd2bin #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flg_mod,
  input  logic [255:0] up,
  input  logic [255:0] un,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] dout,
  output logic         busy
`ifdef RSD_CONV_ZERO_FLG_EN
  ,
  output logic         out_zero
`endif
);

  localparam int N  = 256 / W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [255:0] MP0 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] MP1 =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  typedef enum logic [2:0] {IDLE, SUB, ADD, TRY, DONE} state_t;

  state_t          state, state_next;
  logic [255:0]    up_r, un_r, r, t, t_full, m_sel;
  logic            flg, cy, out_valid_r;
  logic [CW-1:0]   cnt;
  logic            last, accept;
  logic [W-1:0]    a, b;
  logic [W:0]      res;
  int              base;

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_r;
  assign dout      = r;
  assign last      = (cnt == CW'(N - 1));
  assign m_sel     = flg ? MP1 : MP0;
  assign base      = int'(cnt) * W;

  // One shared W+1 bit adder; bit W is the carry (ADD) or the borrow (SUB/TRY).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    a      = '0;
    b      = '0;
    res    = '0;
    t_full = t;
    case (state)
      SUB: begin
        a   = up_r[base +: W];
        b   = un_r[base +: W];
        res = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cy};
      end
      ADD: begin
        a   = r[base +: W];
        b   = m_sel[base +: W];
        res = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cy};
      end
      TRY: begin
        a   = r[base +: W];
        b   = m_sel[base +: W];
        res = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cy};
        t_full[base +: W] = res[W-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = SUB;
      SUB:  if (last) state_next = res[W] ? ADD : TRY;
      ADD:  if (last && res[W]) state_next = TRY;
      TRY:  if (last) state_next = DONE;
      DONE: if (out_valid_r && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide operand/result registers are reset too, so an aborted pass leaves nothing behind.
      up_r        <= '0;
      un_r        <= '0;
      r           <= '0;
      t           <= '0;
      flg         <= 1'b0;
      cy          <= 1'b0;
      cnt         <= '0;
      out_valid_r <= 1'b0;
    end else if (accept) begin
      up_r <= up;
      un_r <= un;
      flg  <= flg_mod;
      cy   <= 1'b0;
      cnt  <= '0;
    end else if (state == SUB || state == ADD || state == TRY) begin
      cnt <= last ? '0 : cnt + 1'b1;
      cy  <= last ? 1'b0 : res[W];
      if (state == TRY) begin
        t[base +: W] <= res[W-1:0];
        if (last && !res[W]) r <= t_full;
      end else begin
        r[base +: W] <= res[W-1:0];
      end
    end else if (state == DONE) begin
      // The first DONE cycle publishes r; the result then holds until taken.
      if (!out_valid_r)    out_valid_r <= 1'b1;
      else if (out_ready)  out_valid_r <= 1'b0;
    end
  end

`ifdef RSD_CONV_ZERO_FLG_EN
  logic zt, zr, zero_r, zt_n, zr_n, first;

  assign first    = (cnt == '0);
  assign zt_n     = (first | zt) & (res[W-1:0] == '0);
  assign zr_n     = (first | zr) & (a == '0);
  assign out_zero = zero_r;

  // Both candidates (t and the kept r) are tracked; the final borrow picks one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zt     <= 1'b0;
      zr     <= 1'b0;
      zero_r <= 1'b0;
    end else if (accept) begin
      zero_r <= 1'b0;
    end else if (state == TRY) begin
      zt <= zt_n;
      zr <= zr_n;
      if (last) zero_r <= res[W] ? zr_n : zt_n;
    end
  end
`endif

endmodule

// File: tb/tb_mod_arith_rsd2bin.sv
// Self-checking bench for mod_arith_rsd2bin: directed and random operands against a big-integer
// reference of (up - un) mod M, with latency, handshake, backpressure and reset-abort checks.
module tb_mod_arith_rsd2bin;

  localparam int W = 32;
  localparam int N = 256 / W;
  localparam logic [255:0] MP0 =
    256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam logic [255:0] MP1 =
    256'hFFFFFFFF00000000FFFFFFFFFFFFFFFFBCE6FAADA7179E84F3B9CAC2FC632551;

  logic         clk, rst_n, in_valid, in_ready, flg_mod, out_valid, out_ready, busy;
  logic [255:0] up, un, dout;
`ifdef RSD_CONV_ZERO_FLG_EN
  logic         out_zero;
`endif

  int tests = 0;
  int fails = 0;

  mod_arith_rsd2bin #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flg_mod   (flg_mod),
    .up        (up),
    .un        (un),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy)
`ifdef RSD_CONV_ZERO_FLG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed difference, folded into [0, M) with plain arithmetic.
  // k counts how many times M must be added to make the difference non-negative.
  function automatic void model(input logic [255:0] u, input logic [255:0] n, input bit f,
                                output logic [255:0] r, output int k);
    logic signed [259:0] d, m;
    m = $signed({4'b0, (f ? MP1 : MP0)});
    d = $signed({4'b0, u}) - $signed({4'b0, n});
    k = 0;
    while (d < 0) begin
      d = d + m;
      k++;
    end
    while (d >= m) d = d - m;
    r = d[255:0];
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v = '0;
    for (int j = 0; j < 8; j++) v = {v[223:0], 32'($urandom)};
    return v;
  endfunction

  // Present an operand pair and return #1 after the edge that accepts it.
  task automatic accept_op(input logic [255:0] u, input logic [255:0] n, input bit f);
    int guard = 0;
    @(negedge clk);
    up = u; un = n; flg_mod = f; in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", 256'(busy), 256'(1));
  endtask

  // Count edges from the accept edge to out_valid and check the result against the model.
  task automatic wait_result(input string tag, input logic [255:0] u, input logic [255:0] n,
                             input bit f);
    logic [255:0] exp_r;
    int k, lat;
    bit busy_ok = 1'b1;
    model(u, n, f, exp_r, k);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (!busy) busy_ok = 1'b0;
      if (out_valid) break;
    end
    check({tag, "_latency"}, 256'(lat), 256'((2 + k) * N + 1));
    check({tag, "_busy"}, 256'(busy_ok), 256'(1));
    check({tag, "_dout"}, dout, exp_r);
`ifdef RSD_CONV_ZERO_FLG_EN
    check({tag, "_zero"}, 256'(out_zero), 256'(exp_r == '0));
`endif
  endtask

  task automatic take_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_ov_clear"}, 256'(out_valid), 256'(0));
    check({tag, "_idle"}, 256'({in_ready, busy}), 256'(2'b10));
    out_ready = 1'b0;
  endtask

  initial begin
    logic [255:0] u, n, held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flg_mod = 1'b0; up = '0; un = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 256'({in_ready, out_valid, busy}), 256'(3'b100));
    check("reset_dout", dout, 256'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: no ADD, one ADD, zero result, two ADD passes.
    accept_op(256'd5, 256'd3, 1'b0);
    wait_result("d5m3", 256'd5, 256'd3, 1'b0);
    check("d5m3_value", dout, 256'd2);
    take_result("d5m3");

    accept_op(256'd0, 256'd1, 1'b0);
    wait_result("pm1", 256'd0, 256'd1, 1'b0);
    check("pm1_value", dout, MP0 - 256'd1);
    take_result("pm1");

    accept_op(MP1, 256'd0, 1'b1);
    wait_result("n_zero", MP1, 256'd0, 1'b1);
    check("n_zero_value", dout, 256'd0);
    take_result("n_zero");

    accept_op(256'd0, {256{1'b1}}, 1'b0);
    wait_result("two_add", 256'd0, {256{1'b1}}, 1'b0);
    take_result("two_add");

    // Random operands; the first run holds out_ready high before out_valid appears.
    for (int i = 0; i < 8; i++) begin
      u = rand256() >> (i * 20);
      n = rand256() >> ((7 - i) * 20);
      out_ready = (i == 0);
      accept_op(u, n, i[0]);
      wait_result("rand", u, n, i[0]);
      take_result("rand");
    end

    // Backpressure: result must hold while a new operand is offered and ignored.
    accept_op(256'd9, 256'd4, 1'b0);
    wait_result("bp", 256'd9, 256'd4, 1'b0);
    held = dout;
    @(negedge clk);
    up = 256'd100; un = 256'd1; flg_mod = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 256'({out_valid, in_ready}), 256'(2'b10));
      check("bp_hold_dout", dout, held);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_idle", 256'({out_valid, in_ready, busy}), 256'(3'b010));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_accept", 256'(busy), 256'(1));
    wait_result("bp_next", 256'd100, 256'd1, 1'b1);
    take_result("bp_next");

    // Reset in the middle of an ADD pass aborts immediately.
    accept_op(256'd0, 256'd1, 1'b0);
    repeat (N + 3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", 256'({out_valid, in_ready, busy}), 256'(3'b010));
    check("abort_dout", dout, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    accept_op(256'd7, 256'd7, 1'b0);
    wait_result("after_abort", 256'd7, 256'd7, 1'b0);
    check("after_abort_value", dout, 256'd0);
    take_result("after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
